// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU execute-to-writeback result stage.
//   - ALU op codes as produced on the ALU control bus
//   - bit positions inside the 4-bit {N, Z, C, V} flag vector
//   - state encoding of the two-entry result stage
//   - helper to recognise a multiply-accumulate op
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_MAC = 4'b0100;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // EMPTY: no entry held; ONE: main slot valid; FULL: main and skid valid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    function automatic logic is_mac(input logic [3:0] op);
        return op == OP_MAC;
    endfunction

endpackage

// File: rtl/alu_stage_slot.sv
// -----------------------------------------------------------------------------
// alu_stage_slot
// One load-enabled entry register {result, flags, rd} with synchronous,
// active-high reset. Used as both the main and the skid slot of the stage.
//
// Ports
//   clk        clock, state changes on rising edge
//   rst        synchronous active-high reset, clears the entry to zero
//   load_i     capture result_i/flags_i/rd_i at the next edge
//   result_i   entry result in
//   flags_i    entry flags in, {N, Z, C, V}
//   rd_i       entry destination register in
//   result_o   held result
//   flags_o    held flags
//   rd_o       held destination register
// -----------------------------------------------------------------------------
module alu_stage_slot
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [3:0]        flags_i,
    input  logic [RD_W-1:0]   rd_i,
    output logic [DATA_W-1:0] result_o,
    output logic [3:0]        flags_o,
    output logic [RD_W-1:0]   rd_o
);

    logic [DATA_W-1:0] result_q;
    logic [3:0]        flags_q;
    logic [RD_W-1:0]   rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            flags_q  <= '0;
            rd_q     <= '0;
        end else if (load_i) begin
            result_q <= result_i;
            flags_q  <= flags_i;
            rd_q     <= rd_i;
        end
    end

    assign result_o = result_q;
    assign flags_o  = flags_q;
    assign rd_o     = rd_q;

endmodule

// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
// Execute-to-writeback stage behind the 32-bit ALU. Captures result, flags
// and destination register through valid/ready, using a main slot plus a skid
// slot so that in_ready can be a register while still sustaining one entry
// per cycle. Also holds the MAC accumulator that feeds the ALU Accumulator
// input.
//
// state | meaning
// ------+--------------------------------------------------
// EMPTY | nothing held, out_valid low
// ONE   | main slot holds the head entry
// FULL  | main holds head, skid holds the next; inputs stalled
//
// Build option: ALU_STAGE_MAC_EN
//   defined   -> accumulator register, MAC capture and acc_clr implemented
//   undefined -> no accumulator flops, acc_value tied to 0, acc_clr ignored,
//                MAC entries flow through as plain results
//
// Ports
//   clk           clock
//   rst           synchronous active-high reset, discards both slots
//   in_valid      ALU result presented
//   in_ready      stage can accept (registered)
//   in_result     ALU result
//   in_flags      {Negative, Zero, Carry, OverFlow}
//   in_alu_ctrl   op code that produced in_result
//   in_rd         destination register
//   acc_clr       clear accumulator, independent of the handshake
//   out_valid     head entry available
//   out_ready     downstream accepts the head entry
//   out_result    head entry result
//   out_flags     head entry flags
//   out_rd        head entry destination
//   acc_value     accumulator, drives ALU Accumulator
//   status_flags  flags of the most recently accepted entry
// -----------------------------------------------------------------------------
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [3:0]        in_flags,
    input  logic [3:0]        in_alu_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              acc_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [3:0]        out_flags,
    output logic [RD_W-1:0]   out_rd,
    output logic [DATA_W-1:0] acc_value,
    output logic [3:0]        status_flags
);

    stage_state_e state_q, state_d;
    logic         in_ready_q;
    logic [3:0]   status_q;

    logic accept;
    logic pop;
    logic main_load;
    logic skid_load;
    logic main_from_skid;

    logic [DATA_W-1:0] skid_result;
    logic [3:0]        skid_flags;
    logic [RD_W-1:0]   skid_rd;

    logic [DATA_W-1:0] main_result_d;
    logic [3:0]        main_flags_d;
    logic [RD_W-1:0]   main_rd_d;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_ONE;
                    main_load = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    main_load = 1'b1;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    skid_load = 1'b1;
                end else if (pop) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only a pop can move the state
                if (pop) begin
                    state_d        = ST_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_comb begin
        if (main_from_skid) begin
            main_result_d = skid_result;
            main_flags_d  = skid_flags;
            main_rd_d     = skid_rd;
        end else begin
            main_result_d = in_result;
            main_flags_d  = in_flags;
            main_rd_d     = in_rd;
        end
    end

    // in_ready is derived from the next state so it is valid the cycle after
    // the transition without a combinational path from out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != ST_FULL);
            if (accept) begin
                status_q <= in_flags;
            end
        end
    end

    assign in_ready     = in_ready_q;
    assign status_flags = status_q;

    alu_stage_slot #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_main (
        .clk      (clk),
        .rst      (rst),
        .load_i   (main_load),
        .result_i (main_result_d),
        .flags_i  (main_flags_d),
        .rd_i     (main_rd_d),
        .result_o (out_result),
        .flags_o  (out_flags),
        .rd_o     (out_rd)
    );

    alu_stage_slot #(
        .DATA_W (DATA_W),
        .RD_W   (RD_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (skid_load),
        .result_i (in_result),
        .flags_i  (in_flags),
        .rd_i     (in_rd),
        .result_o (skid_result),
        .flags_o  (skid_flags),
        .rd_o     (skid_rd)
    );

`ifdef ALU_STAGE_MAC_EN
    logic [DATA_W-1:0] acc_q;

    // Clear wins over a same-cycle MAC capture; the MAC entry itself is
    // queued through the slots regardless.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (acc_clr) begin
            acc_q <= '0;
        end else if (accept && is_mac(in_alu_ctrl)) begin
            acc_q <= in_result;
        end
    end

    assign acc_value = acc_q;
`else
    logic unused_mac_inputs;

    assign unused_mac_inputs = ^{acc_clr, in_alu_ctrl};
    assign acc_value         = '0;
`endif

endmodule
